// File: rtl/ud_counter_array_pkg.sv
// Shared constants and helpers for the stochastic-decoder hard-decision counter array.
// Defaults match the VN/CN blocks so every stage agrees on counter width and saturation.
package ud_counter_array_pkg;

  localparam int DEF_NCH    = 8;
  localparam int DEF_CSIZE  = 4;
  localparam int DEF_SAT    = 7;
  localparam int DEF_WINDOW = 64;
  localparam int DEF_STABLE = 8;

  // Decision controller: running, or finished by convergence / by the cycle window.
  typedef enum logic [1:0] {
    DEC_RUN       = 2'd0,
    DEC_CONVERGED = 2'd1,
    DEC_TIMEOUT   = 2'd2
  } dec_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // SAT must fit the positive half of a CSIZE-bit two's complement count.
  function automatic bit sat_legal(input int csize, input int sat);
    return (csize >= 2) && (sat >= 1) && (sat <= (1 << (csize - 1)) - 1);
  endfunction

endpackage

// File: rtl/ud_counter_array_if.sv
// Channel bit streams in, hard decisions and decode status out.
interface ud_counter_array_if #(
  parameter int NCH = 8,
  parameter int CW  = 7
);
  logic           EN;
  logic [NCH-1:0] BitIN;
  logic [NCH-1:0] BitOUT;
  logic           DONE;
  logic           TIMEOUT;
  logic [CW-1:0]  CYCLES;

  modport master (
    output EN, BitIN,
    input  BitOUT, DONE, TIMEOUT, CYCLES
  );

  modport slave (
    input  EN, BitIN,
    output BitOUT, DONE, TIMEOUT, CYCLES
  );
endinterface

// File: rtl/ud_counter_array_sat_counter.sv
// One channel: saturating up/down counter over a stochastic bit stream.
// Sign is the count MSB, so it is registered and has no path from BitIN.
module ud_sat_counter
  import ud_counter_array_pkg::*;
#(
  parameter int CSIZE = DEF_CSIZE,
  parameter int SAT   = DEF_SAT
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             EN,
  input  logic             BitIN,
  output logic [CSIZE-1:0] Count,
  output logic             Sign
);

  localparam logic [CSIZE-1:0] POS_LIM = CSIZE'(SAT);
  localparam logic [CSIZE-1:0] NEG_LIM = CSIZE'(-SAT);

  if (!sat_legal(CSIZE, SAT)) begin : g_bad_sat
    $fatal(1, "ud_sat_counter: SAT=%0d does not fit CSIZE=%0d", SAT, CSIZE);
  end

  logic [CSIZE-1:0] count_reg;
  logic [CSIZE-1:0] count_next;

  // Equality against the limits is enough: the count never leaves [-SAT, +SAT].
  always_comb begin
    count_next = count_reg;
    if (EN) begin
      if (BitIN) begin
        if (count_reg != POS_LIM) count_next = count_reg + CSIZE'(1);
      end else begin
        if (count_reg != NEG_LIM) count_next = count_reg - CSIZE'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT) count_reg <= '0;
    else      count_reg <= count_next;
  end

  assign Count = count_reg;
  assign Sign  = count_reg[CSIZE-1];

endmodule

// File: rtl/ud_counter_array.sv
// Hard-decision counter array for the stochastic LDPC decoder: NCH channels plus a
// controller that stops the decode on stable decisions or when the cycle window runs out.
module ud_counter_array
  import ud_counter_array_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int CSIZE  = DEF_CSIZE,
  parameter int SAT    = DEF_SAT,
  parameter int WINDOW = DEF_WINDOW,
  parameter int STABLE = DEF_STABLE
) (
  input  logic CLK,
  input  logic INIT,
  ud_counter_array_if.slave bus
);

  localparam int CW = clog2(WINDOW + 1);
  localparam int SW = clog2(STABLE + 1);
  localparam logic [CW-1:0]    WIN_C     = CW'(WINDOW);
  localparam logic [SW-1:0]    STB_C     = SW'(STABLE);
  localparam logic [CSIZE-1:0] MINUS_ONE = '1;

  if (NCH < 1 || WINDOW < 1 || STABLE < 1) begin : g_bad_params
    $fatal(1, "ud_counter_array: NCH, WINDOW and STABLE must all be >= 1");
  end

  dec_state_t       state_reg, state_next;
  logic [CW-1:0]    cycles_reg, cycles_next;
  logic [SW-1:0]    stab_reg, stab_next;
  logic             advance;
  logic [CSIZE-1:0] count_arr [NCH];
  logic [NCH-1:0]   sign_vec;
  logic [NCH-1:0]   sign_flip;

  assign advance = bus.EN && (state_reg == DEC_RUN);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    ud_sat_counter #(
      .CSIZE (CSIZE),
      .SAT   (SAT)
    ) u_ch (
      .CLK   (CLK),
      .INIT  (INIT),
      .EN    (advance),
      .BitIN (bus.BitIN[gi]),
      .Count (count_arr[gi]),
      .Sign  (sign_vec[gi])
    );

    // A sign can only change across the 0 / -1 boundary, so detect that step directly.
    assign sign_flip[gi] = advance &&
                           ((!bus.BitIN[gi] && count_arr[gi] == '0) ||
                            ( bus.BitIN[gi] && count_arr[gi] == MINUS_ONE));
  end

  always_comb begin
    state_next  = state_reg;
    cycles_next = cycles_reg;
    stab_next   = stab_reg;
    if (advance) begin
      if (cycles_reg != WIN_C) cycles_next = cycles_reg + CW'(1);

      if (|sign_flip)            stab_next = '0;
      else if (stab_reg != STB_C) stab_next = stab_reg + SW'(1);

      // Convergence outranks the window limit when both land on the same edge.
      if (stab_next == STB_C)        state_next = DEC_CONVERGED;
      else if (cycles_next == WIN_C) state_next = DEC_TIMEOUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_reg  <= DEC_RUN;
      cycles_reg <= '0;
      stab_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cycles_reg <= cycles_next;
      stab_reg   <= stab_next;
    end
  end

  assign bus.BitOUT  = sign_vec;
  assign bus.DONE    = (state_reg != DEC_RUN);
  assign bus.TIMEOUT = (state_reg == DEC_TIMEOUT);
  assign bus.CYCLES  = cycles_reg;

endmodule

// File: tb/tb_ud_counter_array.sv
// Self-checking bench for ud_counter_array against an integer-arithmetic decode model.
module tb_ud_counter_array;
  import ud_counter_array_pkg::*;

  localparam int NCH    = 8;
  localparam int CSIZE  = 4;
  localparam int SAT    = 7;
  localparam int WINDOW = 64;
  localparam int STABLE = 8;
  localparam int CW     = clog2(WINDOW + 1);
  localparam int OW     = NCH + 2 + CW;

  logic clk  = 1'b0;
  logic init = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ud_counter_array_if #(.NCH(NCH), .CW(CW)) bus ();

  ud_counter_array #(
    .NCH(NCH), .CSIZE(CSIZE), .SAT(SAT), .WINDOW(WINDOW), .STABLE(STABLE)
  ) dut (
    .CLK  (clk),
    .INIT (init),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: signed integer counts, cycle and stability tallies.
  int m_cnt [NCH];
  int m_cyc;
  int m_stab;
  bit m_done;
  bit m_tmo;

  function automatic logic [OW-1:0] model_outs();
    logic [NCH-1:0] s;
    for (int i = 0; i < NCH; i++) s[i] = (m_cnt[i] < 0);
    return {s, m_done, m_tmo, CW'(m_cyc)};
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    return {bus.BitOUT, bus.DONE, bus.TIMEOUT, bus.CYCLES};
  endfunction

  // Stream 1,0,0,1,1,0,0,... : its count's sign toggles every two cycles.
  function automatic bit churn(input int p);
    return (((p + 1) / 2) % 2) == 0;
  endfunction

  task automatic step(input bit ini, input bit en, input logic [NCH-1:0] bits);
    bit changed;
    int nc;
    init    = ini;
    bus.EN  = en;
    bus.BitIN = bits;
    @(posedge clk);
    #1;
    if (ini) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_cyc = 0; m_stab = 0; m_done = 0; m_tmo = 0;
    end else if (en && !m_done) begin
      changed = 0;
      for (int i = 0; i < NCH; i++) begin
        nc = m_cnt[i];
        if (bits[i] && nc < SAT)        nc = nc + 1;
        else if (!bits[i] && nc > -SAT) nc = nc - 1;
        if ((nc < 0) != (m_cnt[i] < 0)) changed = 1;
        m_cnt[i] = nc;
      end
      m_cyc  = (m_cyc < WINDOW) ? m_cyc + 1 : WINDOW;
      m_stab = changed ? 0 : ((m_stab < STABLE) ? m_stab + 1 : STABLE);
      if (m_stab == STABLE)      begin m_done = 1; m_tmo = 0; end
      else if (m_cyc == WINDOW)  begin m_done = 1; m_tmo = 1; end
    end
    $display("txn init=%b en=%b bits=%h -> bitout=%h done=%b tmo=%b cycles=%0d",
             ini, en, bits, bus.BitOUT, bus.DONE, bus.TIMEOUT, bus.CYCLES);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, NCH'($urandom()));
    n_cmp++;
    if (dut_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", dut_outs(), {OW{1'b0}});
    end
  endtask

  task automatic test_up_sat();
    logic [NCH-1:0] bits;
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 18; c++) begin
      bits = (c < 10) ? {NCH{1'b1}} : {NCH{1'b0}};
      bits[NCH-1] = churn(c);
      step(1'b0, 1'b1, bits);
      n_cmp++;
      if (dut_outs() !== model_outs()) begin
        n_err++;
        $display("FAIL up_sat c%0d: got %h want %h", c, dut_outs(), model_outs());
      end
    end
    // +7 held through the up phase, so eight downs are needed to go negative.
    n_cmp++;
    if (bus.BitOUT[NCH-2:0] !== {(NCH-1){1'b1}} || bus.DONE !== 1'b0) begin
      n_err++;
      $display("FAIL up_sat_nowrap: got bitout=%h done=%b want low=7f done=0", bus.BitOUT, bus.DONE);
    end
  endtask

  task automatic test_down_sat();
    logic [NCH-1:0] bits;
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 17; c++) begin
      bits = (c < 10) ? {NCH{1'b0}} : {NCH{1'b1}};
      bits[NCH-1] = churn(c);
      step(1'b0, 1'b1, bits);
      n_cmp++;
      if (dut_outs() !== model_outs()) begin
        n_err++;
        $display("FAIL down_sat c%0d: got %h want %h", c, dut_outs(), model_outs());
      end
      if (c == 0) begin
        n_cmp++;
        if (bus.BitOUT[NCH-2:0] !== {(NCH-1){1'b1}}) begin
          n_err++;
          $display("FAIL down_sat_first: got %h want low all ones", bus.BitOUT);
        end
      end
    end
    n_cmp++;
    if (bus.BitOUT[NCH-2:0] !== {(NCH-1){1'b0}}) begin
      n_err++;
      $display("FAIL down_sat_zero: got %h want low all zeros", bus.BitOUT);
    end
  endtask

  task automatic test_convergence();
    logic [NCH-1:0] pat;
    pat = NCH'(8'h5A);
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 9; c++) begin
      step(1'b0, 1'b1, pat);
      n_cmp++;
      if (dut_outs() !== model_outs()) begin
        n_err++;
        $display("FAIL convergence c%0d: got %h want %h", c, dut_outs(), model_outs());
      end
    end
    n_cmp++;
    if (bus.DONE !== 1'b1 || bus.TIMEOUT !== 1'b0 || bus.CYCLES !== CW'(9) || bus.BitOUT !== ~pat) begin
      n_err++;
      $display("FAIL convergence_final: got done=%b tmo=%b cyc=%0d bitout=%h want 1 0 9 %h",
               bus.DONE, bus.TIMEOUT, bus.CYCLES, bus.BitOUT, ~pat);
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1, NCH'($urandom()));
      n_cmp++;
      if (bus.BitOUT !== ~pat || bus.CYCLES !== CW'(9) || bus.DONE !== 1'b1) begin
        n_err++;
        $display("FAIL convergence_frozen c%0d: got bitout=%h cyc=%0d done=%b want %h 9 1",
                 c, bus.BitOUT, bus.CYCLES, bus.DONE, ~pat);
      end
    end
  endtask

  task automatic test_timeout();
    logic [NCH-1:0] bits;
    logic [NCH-1:0] others;
    others = NCH'($urandom());
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 70; c++) begin
      bits = others;
      bits[0] = churn(c);
      step(1'b0, 1'b1, bits);
      n_cmp++;
      if (dut_outs() !== model_outs()) begin
        n_err++;
        $display("FAIL timeout c%0d: got %h want %h", c, dut_outs(), model_outs());
      end
      if (c == 62) begin
        n_cmp++;
        if (bus.DONE !== 1'b0) begin
          n_err++;
          $display("FAIL timeout_early: got done=%b at cycles=63 want 0", bus.DONE);
        end
      end
    end
    n_cmp++;
    if (bus.DONE !== 1'b1 || bus.TIMEOUT !== 1'b1 || bus.CYCLES !== CW'(WINDOW)) begin
      n_err++;
      $display("FAIL timeout_final: got done=%b tmo=%b cyc=%0d want 1 1 %0d",
               bus.DONE, bus.TIMEOUT, bus.CYCLES, WINDOW);
    end
  endtask

  // Last sign change lands on cycle 56, so stability hits 8 exactly at cycle 64.
  task automatic test_tie();
    logic [NCH-1:0] bits;
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 64; c++) begin
      bits = {NCH{1'b1}};
      if (c < 56) bits[0] = churn(c);
      step(1'b0, 1'b1, bits);
      n_cmp++;
      if (dut_outs() !== model_outs()) begin
        n_err++;
        $display("FAIL tie c%0d: got %h want %h", c, dut_outs(), model_outs());
      end
    end
    n_cmp++;
    if (bus.DONE !== 1'b1 || bus.TIMEOUT !== 1'b0 || bus.CYCLES !== CW'(WINDOW)) begin
      n_err++;
      $display("FAIL tie_final: got done=%b tmo=%b cyc=%0d want 1 0 %0d",
               bus.DONE, bus.TIMEOUT, bus.CYCLES, WINDOW);
    end
  endtask

  task automatic test_en_gating();
    logic [NCH-1:0] bits;
    logic [OW-1:0]  held;
    int p;
    p = 0;
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 15; c++) begin
      bits = NCH'($urandom());
      bits[NCH-1] = churn(p);
      p++;
      step(1'b0, 1'b1, bits);
    end
    held = model_outs();
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0, NCH'($urandom()));
      n_cmp++;
      if (dut_outs() !== held) begin
        n_err++;
        $display("FAIL en_gating c%0d: got %h want %h", c, dut_outs(), held);
      end
    end
    for (int c = 0; c < 10; c++) begin
      bits = NCH'($urandom());
      bits[NCH-1] = churn(p);
      p++;
      step(1'b0, 1'b1, bits);
      n_cmp++;
      if (dut_outs() !== model_outs()) begin
        n_err++;
        $display("FAIL en_resume c%0d: got %h want %h", c, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_init_mid();
    logic [NCH-1:0] bits;
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 20; c++) begin
      bits = NCH'($urandom());
      bits[NCH-1] = churn(c);
      step(1'b0, 1'b1, bits);
    end
    step(1'b1, 1'b1, NCH'($urandom()));
    n_cmp++;
    if (dut_outs() !== '0) begin
      n_err++;
      $display("FAIL init_mid: got %h want %h", dut_outs(), {OW{1'b0}});
    end
    for (int c = 0; c < 12; c++) step(1'b0, 1'b1, NCH'(8'h3C));
    n_cmp++;
    if (bus.DONE !== 1'b1) begin
      n_err++;
      $display("FAIL init_pre_done: got done=%b want 1", bus.DONE);
    end
    step(1'b1, 1'b1, NCH'($urandom()));
    n_cmp++;
    if (dut_outs() !== '0) begin
      n_err++;
      $display("FAIL init_after_done: got %h want %h", dut_outs(), {OW{1'b0}});
    end
    test_convergence();
  endtask

  task automatic test_random();
    int bias [NCH];
    logic [NCH-1:0] bits;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NCH; i++) bias[i] = int'($urandom_range(10, 90));
      step(1'b1, 1'b0, '0);
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < NCH; i++) bits[i] = (int'($urandom_range(0, 99)) < bias[i]);
        step(1'b0, ($urandom_range(0, 3) != 0), bits);
        n_cmp++;
        if (dut_outs() !== model_outs()) begin
          n_err++;
          $display("FAIL random r%0d c%0d: got %h want %h", r, c, dut_outs(), model_outs());
        end
      end
    end
  endtask

  initial begin
    bus.EN    = 1'b0;
    bus.BitIN = '0;
    test_reset();
    test_up_sat();
    test_down_sat();
    test_convergence();
    test_timeout();
    test_tie();
    test_en_gating();
    test_init_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
